subtractor_pipe: RTL and testbench

- Pipelined modular subtractor: computes (a - b) mod P over two operand AXI-stream channels and emits one result stream.
- Counterpart to the pipelined modular adder in the same field-arithmetic datapath. Provides the negation/subtraction leg for point-arithmetic kernels.
- Operands are split into LEVEL equal limbs, one limb per register stage; a borrow/carry chain ripples between stages.
- The backpressure protocol matches the adder pipe, so the two blocks are drop-in interchangeable in the kernel.

---
 rtl/subtractor_pipe.sv | 137 +++++++++++++
 tb/tb_subtractor_pipe.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/subtractor_pipe.sv
// Pipelined modular subtractor: (a - b) mod P over a paired two-channel AXI-stream input.
// Stage g resolves limb g of both a-b (r0) and a-b+P (r1); the final borrow selects the result.
module subtractor_pipe #(
  parameter int P              = 100,
  parameter int BITS           = $clog2(P),
  parameter int C_DATA_WIDTH   = 32,
  parameter int C_NUM_CHANNELS = 2,
  parameter int CTL_BITS       = 8,
  parameter int LEVEL          = 1
) (
  input  logic                                        aclk,
  input  logic                                        areset,
  input  logic [C_NUM_CHANNELS-1:0]                   s_tvalid,
  input  logic [C_NUM_CHANNELS-1:0][C_DATA_WIDTH-1:0] s_tdata,
  input  logic [CTL_BITS-1:0]                         s_tuser,
  output logic [C_NUM_CHANNELS-1:0]                   s_tready,
  output logic                                        m_tvalid,
  output logic [C_DATA_WIDTH-1:0]                     m_tdata,
  output logic [CTL_BITS-1:0]                         m_tuser,
  input  logic                                        m_tready
);

  localparam int DAT_BITS = ((BITS + LEVEL - 1) / LEVEL) * LEVEL;
  localparam int L        = DAT_BITS / LEVEL;
  localparam logic [DAT_BITS-1:0] P_VEC = DAT_BITS'(P);

  logic [LEVEL-1:0]    val_q, bw_q, cy_q;
  logic [DAT_BITS-1:0] a_q    [LEVEL];
  logic [DAT_BITS-1:0] b_q    [LEVEL];
  logic [DAT_BITS-1:0] r0_q   [LEVEL];
  logic [DAT_BITS-1:0] r1_q   [LEVEL];
  logic [CTL_BITS-1:0] user_q [LEVEL];

  logic [LEVEL-1:0]    src_val, src_bw, src_cy;
  logic [DAT_BITS-1:0] src_a    [LEVEL];
  logic [DAT_BITS-1:0] src_b    [LEVEL];
  logic [DAT_BITS-1:0] src_r0   [LEVEL];
  logic [DAT_BITS-1:0] src_r1   [LEVEL];
  logic [CTL_BITS-1:0] src_user [LEVEL];

  logic [LEVEL-1:0]    nx_bw, nx_cy;
  logic [DAT_BITS-1:0] nx_r0 [LEVEL];
  logic [DAT_BITS-1:0] nx_r1 [LEVEL];

  logic [LEVEL:0] rdy;
  logic           pair_valid;
  logic           unused_ok;

  assign pair_valid = s_tvalid[0] & s_tvalid[1];
  assign s_tready   = {C_NUM_CHANNELS{rdy[0] & pair_valid & ~areset}};

  // A stage may load when it is empty or the stage after it is moving.
  always_comb begin
    rdy        = '0;
    rdy[LEVEL] = m_tready;
    for (int g = LEVEL - 1; g >= 0; g--) begin
      rdy[g] = rdy[g+1] | ~val_q[g];
    end
  end

  always_comb begin
    src_val[0]  = pair_valid;
    src_a[0]    = DAT_BITS'(s_tdata[0][BITS-1:0]);
    src_b[0]    = DAT_BITS'(s_tdata[1][BITS-1:0]);
    src_r0[0]   = '0;
    src_r1[0]   = '0;
    src_bw[0]   = 1'b0;
    src_cy[0]   = 1'b0;
    src_user[0] = s_tuser;
    for (int g = 1; g < LEVEL; g++) begin
      src_val[g]  = val_q[g-1];
      src_a[g]    = a_q[g-1];
      src_b[g]    = b_q[g-1];
      src_r0[g]   = r0_q[g-1];
      src_r1[g]   = r1_q[g-1];
      src_bw[g]   = bw_q[g-1];
      src_cy[g]   = cy_q[g-1];
      src_user[g] = user_q[g-1];
    end
  end

  // The carry into the r1 limb follows d0 + P, independent of the borrow chain.
  always_comb begin
    logic [L:0] diff;
    logic [L:0] sum;
    diff  = '0;
    sum   = '0;
    nx_bw = '0;
    nx_cy = '0;
    for (int g = 0; g < LEVEL; g++) begin
      diff = {1'b0, src_a[g][g*L +: L]} - {1'b0, src_b[g][g*L +: L]} - (L+1)'(src_bw[g]);
      sum  = {1'b0, diff[L-1:0]} + {1'b0, P_VEC[g*L +: L]} + (L+1)'(src_cy[g]);
      nx_r0[g]          = src_r0[g];
      nx_r0[g][g*L +: L] = diff[L-1:0];
      nx_r1[g]          = src_r1[g];
      nx_r1[g][g*L +: L] = sum[L-1:0];
      nx_bw[g] = diff[L];
      nx_cy[g] = sum[L];
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      val_q <= '0;
      bw_q  <= '0;
      cy_q  <= '0;
      for (int g = 0; g < LEVEL; g++) begin
        a_q[g]    <= '0;
        b_q[g]    <= '0;
        r0_q[g]   <= '0;
        r1_q[g]   <= '0;
        user_q[g] <= '0;
      end
    end else begin
      for (int g = 0; g < LEVEL; g++) begin
        if (rdy[g]) begin
          val_q[g]  <= src_val[g];
          a_q[g]    <= src_a[g];
          b_q[g]    <= src_b[g];
          r0_q[g]   <= nx_r0[g];
          r1_q[g]   <= nx_r1[g];
          bw_q[g]   <= nx_bw[g];
          cy_q[g]   <= nx_cy[g];
          user_q[g] <= src_user[g];
        end
      end
    end
  end

  assign m_tvalid = val_q[LEVEL-1];
  assign m_tuser  = user_q[LEVEL-1];
  assign m_tdata  = C_DATA_WIDTH'(bw_q[LEVEL-1] ? r1_q[LEVEL-1] : r0_q[LEVEL-1]);

  // Upper operand bits and the top-limb carry are deliberately dropped.
  assign unused_ok = ^{s_tdata, cy_q[LEVEL-1], a_q[LEVEL-1], b_q[LEVEL-1]};

endmodule

// File: tb/tb_subtractor_pipe.sv
// Directed bench for subtractor_pipe: a P=100/LEVEL=1 instance and a P=1000003/LEVEL=4 instance.
module tb_subtractor_pipe;

  logic aclk = 1'b0;
  logic areset;

  logic [1:0]       p1_s_tvalid, p1_s_tready;
  logic [1:0][31:0] p1_s_tdata;
  logic [7:0]       p1_s_tuser, p1_m_tuser;
  logic             p1_m_tvalid, p1_m_tready;
  logic [31:0]      p1_m_tdata;

  logic [1:0]       p4_s_tvalid, p4_s_tready;
  logic [1:0][31:0] p4_s_tdata;
  logic [7:0]       p4_s_tuser, p4_m_tuser;
  logic             p4_m_tvalid, p4_m_tready;
  logic [31:0]      p4_m_tdata;

  int n_assert = 0;
  int n_fail   = 0;

  int unsigned l1_a   [4] = '{30, 10, 57, 0};
  int unsigned l1_b   [4] = '{10, 30, 57, 99};
  int unsigned l1_exp [4] = '{20, 80, 0, 1};

  int unsigned bp_a   [8] = '{100, 40, 1000002, 0, 123456, 654321, 500000, 31};
  int unsigned bp_b   [8] = '{40, 100, 0, 1000002, 654321, 123456, 500000, 32};
  int unsigned bp_exp [8] = '{60, 999943, 1000002, 1, 469138, 530865, 0, 1000002};

  subtractor_pipe #(.P(100), .LEVEL(1)) u_p1 (
    .aclk(aclk), .areset(areset),
    .s_tvalid(p1_s_tvalid), .s_tdata(p1_s_tdata), .s_tuser(p1_s_tuser), .s_tready(p1_s_tready),
    .m_tvalid(p1_m_tvalid), .m_tdata(p1_m_tdata), .m_tuser(p1_m_tuser), .m_tready(p1_m_tready)
  );

  subtractor_pipe #(.P(1000003), .BITS(20), .LEVEL(4)) u_p4 (
    .aclk(aclk), .areset(areset),
    .s_tvalid(p4_s_tvalid), .s_tdata(p4_s_tdata), .s_tuser(p4_s_tuser), .s_tready(p4_s_tready),
    .m_tvalid(p4_m_tvalid), .m_tdata(p4_m_tdata), .m_tuser(p4_m_tuser), .m_tready(p4_m_tready)
  );

  always #5 aclk = ~aclk;

  task automatic applyStimulus(input logic [1:0] v, input int unsigned a, input int unsigned b,
                               input logic [7:0] u);
    p4_s_tvalid   = v;
    p4_s_tdata[0] = a;
    p4_s_tdata[1] = b;
    p4_s_tuser    = u;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_assert++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Called just after a negedge; returns how many cycles until m_tvalid, or -1.
  task automatic waitValid4(output int cycles);
    cycles = -1;
    for (int c = 1; c <= 20; c++) begin
      #1;
      if (p4_m_tvalid) begin
        cycles = c;
        break;
      end
      @(negedge aclk);
    end
  endtask

  initial begin
    int lat, in_idx, out_idx, occ;
    logic saw_full, prev_stall, seen;
    logic [31:0] prev_data;
    logic [1:0] exp_rdy;

    areset      = 1'b1;
    p1_s_tvalid = 2'b11;
    p1_s_tdata  = '0;
    p1_s_tuser  = '0;
    p1_m_tready = 1'b1;
    p4_m_tready = 1'b1;
    applyStimulus(2'b11, 0, 0, 8'h00);

    repeat (2) @(negedge aclk);
    #1;
    checkOutput("rst_p4_s_tready", 32'(p4_s_tready), 32'd0);
    checkOutput("rst_p4_m_tvalid", 32'(p4_m_tvalid), 32'd0);
    checkOutput("rst_p4_m_tdata", p4_m_tdata, 32'd0);
    checkOutput("rst_p4_m_tuser", 32'(p4_m_tuser), 32'd0);
    checkOutput("rst_p1_s_tready", 32'(p1_s_tready), 32'd0);
    checkOutput("rst_p1_m_tvalid", 32'(p1_m_tvalid), 32'd0);

    @(negedge aclk);
    areset      = 1'b0;
    p1_s_tvalid = 2'b00;
    applyStimulus(2'b00, 0, 0, 8'h00);

    // LEVEL=1 directed vectors, back to back
    for (int i = 0; i < 4; i++) begin
      @(negedge aclk);
      p1_s_tvalid   = 2'b11;
      p1_s_tdata[0] = l1_a[i];
      p1_s_tdata[1] = l1_b[i];
      p1_s_tuser    = 8'(i + 1);
      #1;
      checkOutput("l1_s_tready", 32'(p1_s_tready), 32'd3);
      if (i > 0) begin
        checkOutput("l1_m_tvalid", 32'(p1_m_tvalid), 32'd1);
        checkOutput("l1_m_tdata", p1_m_tdata, l1_exp[i-1]);
        checkOutput("l1_m_tuser", 32'(p1_m_tuser), 32'(i));
      end
    end
    @(negedge aclk);
    p1_s_tvalid = 2'b00;
    #1;
    checkOutput("l1_m_tvalid_last", 32'(p1_m_tvalid), 32'd1);
    checkOutput("l1_m_tdata_last", p1_m_tdata, l1_exp[3]);
    @(negedge aclk);
    #1;
    checkOutput("l1_m_tvalid_idle", 32'(p1_m_tvalid), 32'd0);

    // LEVEL=4 latency: 5 - 6 -> 1000002
    @(negedge aclk);
    applyStimulus(2'b11, 5, 6, 8'h11);
    #1;
    checkOutput("l4_s_tready", 32'(p4_s_tready), 32'd3);
    @(negedge aclk);
    applyStimulus(2'b00, 0, 0, 8'h00);
    waitValid4(lat);
    checkOutput("l4_latency", 32'(lat), 32'd4);
    checkOutput("l4_m_tdata_a", p4_m_tdata, 32'd1000002);
    checkOutput("l4_m_tuser_a", 32'(p4_m_tuser), 32'h11);

    @(negedge aclk);
    applyStimulus(2'b11, 999999, 3, 8'h22);
    @(negedge aclk);
    applyStimulus(2'b00, 0, 0, 8'h00);
    waitValid4(lat);
    checkOutput("l4_latency_b", 32'(lat), 32'd4);
    checkOutput("l4_m_tdata_b", p4_m_tdata, 32'd999996);

    // LEVEL=4 stream of 8 beats with a 6-cycle downstream stall
    in_idx     = 0;
    out_idx    = 0;
    saw_full   = 1'b0;
    prev_stall = 1'b0;
    prev_data  = '0;
    for (int cyc = 0; cyc < 60 && out_idx < 8; cyc++) begin
      @(negedge aclk);
      p4_m_tready = !(cyc >= 3 && cyc < 9);
      if (in_idx < 8) applyStimulus(2'b11, bp_a[in_idx], bp_b[in_idx], 8'(in_idx));
      else            applyStimulus(2'b00, 0, 0, 8'h00);
      #1;
      occ = in_idx - out_idx;
      if (in_idx < 8) begin
        exp_rdy = (occ < 4 || p4_m_tready) ? 2'b11 : 2'b00;
        checkOutput("bp_s_tready", 32'(p4_s_tready), 32'(exp_rdy));
        if (occ == 4 && !p4_m_tready) saw_full = 1'b1;
      end
      if (prev_stall) begin
        checkOutput("bp_hold_valid", 32'(p4_m_tvalid), 32'd1);
        checkOutput("bp_hold_data", p4_m_tdata, prev_data);
      end
      if (p4_m_tvalid && p4_m_tready) begin
        checkOutput("bp_m_tdata", p4_m_tdata, bp_exp[out_idx]);
        checkOutput("bp_m_tuser", 32'(p4_m_tuser), 32'(out_idx));
        out_idx++;
      end
      if (in_idx < 8 && p4_s_tready[0]) in_idx++;
      prev_stall = p4_m_tvalid && !p4_m_tready;
      prev_data  = p4_m_tdata;
    end
    checkOutput("bp_out_count", 32'(out_idx), 32'd8);
    checkOutput("bp_saw_full", 32'(saw_full), 32'd1);
    p4_m_tready = 1'b1;
    @(negedge aclk);
    applyStimulus(2'b00, 0, 0, 8'h00);
    #1;
    checkOutput("bp_drained", 32'(p4_m_tvalid), 32'd0);

    // Unpaired channel 0 is never acknowledged
    for (int k = 0; k < 5; k++) begin
      @(negedge aclk);
      applyStimulus(2'b01, 20, 7, 8'hA5);
      #1;
      checkOutput("unpaired_s_tready", 32'(p4_s_tready), 32'd0);
      checkOutput("unpaired_m_tvalid", 32'(p4_m_tvalid), 32'd0);
    end
    @(negedge aclk);
    applyStimulus(2'b11, 20, 7, 8'hA5);
    #1;
    checkOutput("paired_s_tready", 32'(p4_s_tready), 32'd3);
    @(negedge aclk);
    applyStimulus(2'b00, 0, 0, 8'h00);
    waitValid4(lat);
    checkOutput("paired_latency", 32'(lat), 32'd4);
    checkOutput("paired_m_tdata", p4_m_tdata, 32'd13);
    checkOutput("paired_m_tuser", 32'(p4_m_tuser), 32'hA5);
    @(negedge aclk);
    #1;
    checkOutput("paired_single", 32'(p4_m_tvalid), 32'd0);

    // Reset with three beats in flight
    for (int k = 0; k < 3; k++) begin
      @(negedge aclk);
      applyStimulus(2'b11, 10 + k, 1, 8'(k));
    end
    @(negedge aclk);
    applyStimulus(2'b00, 0, 0, 8'h00);
    areset = 1'b1;
    @(negedge aclk);
    areset = 1'b0;
    #1;
    checkOutput("rst_mid_m_tvalid", 32'(p4_m_tvalid), 32'd0);
    seen = 1'b0;
    repeat (6) begin
      @(negedge aclk);
      #1;
      if (p4_m_tvalid) seen = 1'b1;
    end
    checkOutput("rst_mid_no_ghost", 32'(seen), 32'd0);
    @(negedge aclk);
    applyStimulus(2'b11, 7, 2, 8'h33);
    @(negedge aclk);
    applyStimulus(2'b00, 0, 0, 8'h00);
    waitValid4(lat);
    checkOutput("rst_mid_latency", 32'(lat), 32'd4);
    checkOutput("rst_mid_m_tdata", p4_m_tdata, 32'd5);
    checkOutput("rst_mid_m_tuser", 32'(p4_m_tuser), 32'h33);

    @(negedge aclk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
